// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared constants and output-buffer occupancy encoding for the
//            FIFO stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_DATA_W_DEFAULT = 8;
  localparam int FIFO_CNT_W_DEFAULT  = 16;
  localparam int SKID_DEPTH          = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  function automatic logic [1:0] occ_count(input occ_state_e s);
    return (s == TWO) ? 2'd2 : ((s == ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader_if
// Purpose  : FIFO read port plus valid/ready stream bundle of the reader.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int data_size = FIFO_DATA_W_DEFAULT
) ();
  logic                 fifo_empty;
  logic [data_size-1:0] fifo_dout;
  logic                 fifo_readEN;
  logic                 m_valid;
  logic [data_size-1:0] m_data;
  logic                 m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_readEN, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_readEN, m_valid, m_data
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Purpose  : Two-entry in-order output buffer; head is always the oldest beat.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int data_size = FIFO_DATA_W_DEFAULT
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 capture,
  input  wire logic                 pop,
  input  wire logic [data_size-1:0] din,
  output logic [data_size-1:0]      head,
  output logic                      valid,
  output logic [1:0]                occ
);
  occ_state_e           state_q, state_d;
  logic [data_size-1:0] ent0_q, ent0_d;
  logic [data_size-1:0] ent1_q, ent1_d;
  logic                 pop_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    pop_ok  = pop && (state_q != EMPTY);
    case (state_q)
      EMPTY: begin
        if (capture) begin
          ent0_d  = din;
          state_d = ONE;
        end
      end
      ONE: begin
        if (capture && pop_ok) begin
          ent0_d = din;
        end else if (capture) begin
          ent1_d  = din;
          state_d = TWO;
        end else if (pop_ok) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // the read gate upstream never lets a capture arrive here without a pop
        if (pop_ok) begin
          ent0_d = ent1_q;
          if (capture) begin
            ent1_d = din;
          end else begin
            state_d = ONE;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign head  = ent0_q;
  assign valid = (state_q != EMPTY);
  assign occ   = occ_count(state_q);

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a 1-cycle-latency synchronous FIFO into a valid/ready
//            stream without bubbles, counting delivered beats.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int data_size = FIFO_DATA_W_DEFAULT,
  parameter int CNT_W     = FIFO_CNT_W_DEFAULT
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     beat_count,
  output logic                 busy
);
  logic                 inflight_q, inflight_d;
  logic [CNT_W-1:0]     beat_count_q, beat_count_d;
  logic                 skid_valid;
  logic [1:0]           skid_occ;
  logic [data_size-1:0] skid_head;
  logic                 pop;
  logic                 read_en;
  logic [2:0]           load;

  fifo_rd_skid #(
    .data_size(data_size)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .capture(inflight_q),
    .pop    (pop),
    .din    (bus.fifo_dout),
    .head   (skid_head),
    .valid  (skid_valid),
    .occ    (skid_occ)
  );

  always_comb begin
    pop  = skid_valid && bus.m_ready;
    // held entries plus the one in flight, less the one leaving, must leave a free slot
    load = {1'b0, skid_occ} + {2'b00, inflight_q};
    read_en      = enable && !bus.fifo_empty && !rst && (load < (3'd2 + {2'b00, pop}));
    inflight_d   = read_en;
    beat_count_d = pop ? (beat_count_q + CNT_W'(1)) : beat_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q   <= 1'b0;
      beat_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign bus.fifo_readEN = read_en;
  assign bus.m_valid     = skid_valid;
  assign bus.m_data      = skid_head;
  assign beat_count      = beat_count_q;
  assign busy            = skid_valid || inflight_q;

endmodule
`default_nettype wire
